// File: rtl/multisim_push_arbiter.sv
// Round-robin push arbiter: NUM_REQ requesters share one registered output
// channel, and a multi-beat burst keeps its grant until the beat marked last.
module multisim_push_arbiter #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 64,
   localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_vld,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_rdy,
   input  logic                          out_rdy,
   output logic                          out_vld,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [ID_WIDTH-1:0]           out_id,
   output logic                          out_last
);

   localparam int SUM_W = ID_WIDTH + 1;
   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_e;

   state_e                  state_q,    state_d;
   logic [ID_WIDTH-1:0]     rr_ptr_q,   rr_ptr_d;
   logic [ID_WIDTH-1:0]     lock_id_q,  lock_id_d;
   logic                    out_vld_q,  out_vld_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic [ID_WIDTH-1:0]     out_id_q,   out_id_d;
   logic                    out_last_q, out_last_d;

   logic                    slot_free;
   logic                    win_found;
   logic [ID_WIDTH-1:0]     win_id;
   logic [SUM_W-1:0]        cand_sum;
   logic                    accept;
   logic [ID_WIDTH-1:0]     gnt_id;
   logic [NUM_REQ-1:0]      rdy;
   logic [DATA_WIDTH-1:0]   gnt_data;
   logic                    gnt_last;

   // The output register can take a beat when empty or when it drains this cycle.
   assign slot_free = !out_vld_q || out_rdy;

   // Round-robin search: first asserted req_vld at or after rr_ptr, wrapping.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves a value unassigned and no latch is inferred.
      win_found = 1'b0;
      win_id    = '0;
      cand_sum  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
         if (cand_sum >= SUM_W'(NUM_REQ)) begin
            cand_sum = cand_sum - SUM_W'(NUM_REQ);
         end
         if (!win_found && req_vld[cand_sum[ID_WIDTH-1:0]]) begin
            win_found = 1'b1;
            win_id    = cand_sum[ID_WIDTH-1:0];
         end
      end
   end

   // Grant: a locked owner keeps req_rdy even while its req_vld is low.
   always_comb begin
      rdy    = '0;
      accept = 1'b0;
      gnt_id = win_id;
      if (!rst && slot_free) begin
         if (state_q == ST_LOCKED) begin
            gnt_id         = lock_id_q;
            rdy[lock_id_q] = 1'b1;
            accept         = req_vld[lock_id_q];
         end else if (win_found) begin
            rdy[win_id] = 1'b1;
            accept      = 1'b1;
         end
      end
   end

   assign req_rdy = rdy;

   always_comb begin
      gnt_data = '0;
      gnt_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_WIDTH'(i) == gnt_id) begin
            gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            gnt_last = req_last[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_id_d  = lock_id_q;
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_id_d   = out_id_q;
      out_last_d = out_last_q;

      if (accept) begin
         out_vld_d  = 1'b1;
         out_data_d = gnt_data;
         out_id_d   = gnt_id;
         out_last_d = gnt_last;
         if (gnt_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_WIDTH'(1);
         end else begin
            state_d   = ST_LOCKED;
            lock_id_d = gnt_id;
         end
      end else if (out_vld_q && out_rdy) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         lock_id_q  <= '0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_id_q   <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_id_q  <= lock_id_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_id_q   <= out_id_d;
         out_last_q <= out_last_d;
      end
   end

   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;
   assign out_id   = out_id_q;
   assign out_last = out_last_q;

endmodule

// File: doc/multisim_push_arbiter.md
MULTISIM_PUSH_ARBITER -- requirements
Module: multisim_push_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one push channel (legal range 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, payload width per beat.
REQ-003 SHALL have derived localparam ID_WIDTH = $clog2(NUM_REQ), width of the requester index.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_vld  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_last  input  NUM_REQ  per-requester last-beat-of-burst flag, qualified by req_vld.
REQ-008 SHALL have port req_data  input  NUM_REQ x DATA_WIDTH  per-requester payload, packed with requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_rdy  output  NUM_REQ  per-requester accept; beat i transfers on a posedge with req_vld[i] && req_rdy[i].
REQ-010 SHALL have port out_rdy  input  1  downstream ready (data_rdy of multisim_client_push).
REQ-011 SHALL have port out_vld  output  1  downstream valid (data_vld of multisim_client_push).
REQ-012 SHALL have port out_data  output  DATA_WIDTH  downstream payload.
REQ-013 SHALL have port out_id  output  ID_WIDTH  index of the requester that owns out_data.
REQ-014 SHALL have port out_last  output  1  last-beat flag travelling with out_data.

Function
REQ-015 SHALL hold the output in one register stage (out_vld/out_data/out_id/out_last); a downstream transfer occurs on a posedge with out_vld && out_rdy.
REQ-016 SHALL define slot_free = !out_vld || out_rdy (register empty or draining this cycle).
REQ-017 SHALL implement arbitration FSM states IDLE (no burst owner) and LOCKED (owner = lock_id).
REQ-018 In IDLE with slot_free, SHALL grant the first asserted req_vld at or after rr_ptr, wrapping NUM_REQ-1 -> 0; req_rdy is combinational, one-hot or zero, asserted only for the winner.
REQ-019 In LOCKED with slot_free, SHALL assert req_rdy[lock_id] only, irrespective of other req_vld; others stall.
REQ-020 When slot_free is low, SHALL drive req_rdy all-zero.
REQ-021 On an accepted beat from requester g, SHALL load out_data=req_data[g], out_id=g, out_last=req_last[g], out_vld=1 at that edge (one-cycle latency, input beat to out_vld).
REQ-022 On a downstream transfer with no simultaneous accepted input beat, SHALL clear out_vld at that edge; with a simultaneous accepted beat, SHALL load the new beat with no bubble (full throughput).
REQ-023 On an accepted beat with req_last[g]=0, SHALL go/stay LOCKED with lock_id=g.
REQ-024 On an accepted beat with req_last[g]=1, SHALL go to IDLE and set rr_ptr = (g+1) mod NUM_REQ; rr_ptr is otherwise unchanged.
REQ-025 Single-beat bursts (req_last=1 on first beat) SHALL never enter LOCKED.
REQ-026 With no req_vld asserted, SHALL leave FSM, rr_ptr and lock_id unchanged.
REQ-027 Out register contents SHALL stay stable while out_vld && !out_rdy.
REQ-028 A requester dropping req_vld mid-burst SHALL leave the arbiter LOCKED on it; no timeout, no preemption.

Reset
REQ-029 On rst=1 at a posedge: out_vld=0, out_data=0, out_id=0, out_last=0, FSM=IDLE, rr_ptr=0, lock_id=0.
REQ-030 During rst=1, req_rdy SHALL be all-zero; a beat presented then is not accepted.
REQ-031 Reset mid-burst or with out_vld=1 SHALL discard the held beat and lock; the first post-reset grant follows REQ-018 from rr_ptr=0.

Verification
REQ-032 NUM_REQ=4, all req_vld=1, req_last=1, out_rdy=1 continuously -> out_id sequence 0,1,2,3,0,... one beat per cycle, first out_vld one cycle after rst release.
REQ-033 Req 2 sends 3-beat burst (data 0xA,0xB,0xC, last on 0xC) while req 0 and 3 assert vld -> out_id=2 for 3 consecutive beats, then 3, then 0.
REQ-034 out_vld=1 holding 0x55, out_rdy=0 for 5 cycles -> out_data stays 0x55, req_rdy=0; out_rdy=1 -> 0x55 transfers and next granted beat appears the following cycle.
REQ-035 Only req 1 valid, req_last=1, rr_ptr=3 -> grant wraps to 1; rr_ptr becomes 2.
REQ-036 Assert rst while LOCKED on req 1 with out_vld=1 -> next cycle out_vld=0, out_id=0; after release req 0 and 1 valid with last=1 -> req 0 granted first.
